tdm_demux4: RTL

- Receive end of the team's 4-channel time-division link; the transmit side is the 4-to-1 mux driven by a rotating 2-bit select.
- Accepts one serialized WIDTH-bit sample per valid beat, tracks the slot position with a counter locked to a frame-sync marker, and delivers all four channels together as coherent parallel registers once per frame.
- Sits between the serial link and the per-channel consumers. Detects sync loss and re-acquires lock automatically.

---
 rtl/tdm_demux4_if.sv | 26 ++
 rtl/tdm_demux4.sv | 81 ++++++++
 2 files changed

// File: rtl/tdm_demux4_if.sv
// tdm_demux4_if: serial TDM link in, four coherent channel registers plus status out.
interface tdm_demux4_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             frame_sync;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out3;
    logic             frame_valid;
    logic [1:0]       slot;
    logic             locked;
    logic             sync_err;

    modport master (
        output din, din_valid, frame_sync,
        input  out0, out1, out2, out3, frame_valid, slot, locked, sync_err
    );

    modport slave (
        input  din, din_valid, frame_sync,
        output out0, out1, out2, out3, frame_valid, slot, locked, sync_err
    );
endinterface

// File: rtl/tdm_demux4.sv
// tdm_demux4: 4-channel TDM receiver; slot counter locked to frame_sync, frames
// staged in shadow registers and published to out0..out3 only when complete.
module tdm_demux4 #(
    parameter int WIDTH = 8
) (
    input logic         clk,
    input logic         reset,
    tdm_demux4_if.slave bus
);
    typedef enum logic {HUNT, LOCKED} state_t;

    state_t           state, state_d;
    logic [1:0]       slot, slot_d;
    logic [WIDTH-1:0] sh0, sh1, sh2;
    logic [WIDTH-1:0] out0, out1, out2, out3;
    logic             frame_valid, sync_err;
    logic             take0, take1, take2, complete, err;

    wire beat = bus.din_valid;
    wire fs   = bus.din_valid & bus.frame_sync;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= HUNT;
        else       state <= state_d;

    always_comb begin
        state_d = state;
        if (state == HUNT)
            state_d = fs ? LOCKED : HUNT;
        else if (beat && !fs && slot == 2'd0)
            state_d = HUNT;
    end

    // Any sync beat restarts the frame at slot 0, whether hunting or early.
    always_comb begin
        take0    = fs;
        take1    = beat && !fs && state == LOCKED && slot == 2'd1;
        take2    = beat && !fs && state == LOCKED && slot == 2'd2;
        complete = beat && !fs && state == LOCKED && slot == 2'd3;
        err      = beat && state == LOCKED && (fs ? slot != 2'd0 : slot == 2'd0);
        slot_d   = !beat ? slot :
                   fs ? 2'd1 :
                   (state == LOCKED && slot != 2'd0) ? slot + 2'd1 : 2'd0;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            slot        <= '0;
            sh0         <= '0;
            sh1         <= '0;
            sh2         <= '0;
            out0        <= '0;
            out1        <= '0;
            out2        <= '0;
            out3        <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            slot        <= slot_d;
            frame_valid <= complete;
            sync_err    <= err;
            if (take0) sh0 <= bus.din;
            if (take1) sh1 <= bus.din;
            if (take2) sh2 <= bus.din;
            if (complete) begin
                out0 <= sh0;
                out1 <= sh1;
                out2 <= sh2;
                out3 <= bus.din;
            end
        end

    assign bus.out0        = out0;
    assign bus.out1        = out1;
    assign bus.out2        = out2;
    assign bus.out3        = out3;
    assign bus.frame_valid = frame_valid;
    assign bus.sync_err    = sync_err;
    assign bus.slot        = slot;
    assign bus.locked      = state == LOCKED;
endmodule
